// File: rtl/multdiv_unit_if.sv
// Start/operand/result bundle between the X/PW pipeline stages and the
// sequential multiply/divide engine.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Sequential signed multiply (radix-2 shift-add) / divide (restoring) engine
// with a fixed 32-cycle latency and a one-cycle ready pulse.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, next_state;
  logic [4:0]         count;
  logic               is_mult;
  logic               neg_result;
  logic               div_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;
  logic               busy_q;

  logic               start;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] signed_prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH:0]     prod_upper;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      RUN:     if (count == 5'd31) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (start) next_state = RUN;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (is_mult)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_shift >= {1'b0, mag_b})
      acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    signed_prod = neg_result ? -acc_next : acc_next;
    quot        = neg_result ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    prod_upper  = signed_prod[2*WIDTH-1:WIDTH-1];

    fin_result = quot;
    fin_exc    = 1'b0;
    if (is_mult) begin
      fin_result = signed_prod[WIDTH-1:0];
      fin_exc    = !((&prod_upper) | (~|prod_upper));
    end else if (div_zero) begin
      fin_result = {WIDTH{1'b0}};
      fin_exc    = 1'b1;
    end else if (div_ovf) begin
      fin_result = MIN_NEG;
      fin_exc    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 5'd0;
      is_mult    <= 1'b0;
      neg_result <= 1'b0;
      div_zero   <= 1'b0;
      div_ovf    <= 1'b0;
      mag_a      <= {WIDTH{1'b0}};
      mag_b      <= {WIDTH{1'b0}};
      acc        <= {(2*WIDTH){1'b0}};
      result_q   <= {WIDTH{1'b0}};
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state == RUN);
      rdy_q  <= (next_state == DONE);
      // A start always wins, aborting whatever was in flight
      if (start) begin
        is_mult    <= bus.ctrl_MULT;
        neg_result <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        div_zero   <= (bus.data_operandB == {WIDTH{1'b0}});
        div_ovf    <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == {WIDTH{1'b1}});
        mag_a      <= abs_a;
        mag_b      <= abs_b;
        acc        <= {{WIDTH{1'b0}}, (bus.ctrl_MULT ? abs_b : abs_a)};
        count      <= 5'd0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        count <= count + 5'd1;
        if (count == 5'd31) begin
          result_q <= fin_result;
          exc_q    <= fin_exc;
        end
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes expected results with a
// due cycle, a negedge monitor pops and compares on every ready pulse.
module tb_multdiv_unit;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic        mult;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_rdy = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multdiv_unit_if #(.WIDTH(32)) bus();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue({e.name, " result"}, bus.data_result, e.result);
    checkValue({e.name, " exception"}, {31'd0, bus.data_exception}, {31'd0, e.exc});
    checkValue({e.name, " rdy_cycle"}, cyc, e.due);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (bus.data_resultRDY === 1'b1) begin
      checkValue("rdy_not_back_to_back", {31'd0, prev_rdy}, 32'd0);
      checkValue("busy_low_in_rdy", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rdy: got pulse at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
    prev_rdy = bus.data_resultRDY;
  end

  task automatic applyStimulus(input logic mult, input logic div, input logic [31:0] a,
                               input logic [31:0] b, input bit push,
                               input logic [31:0] res, input logic exc, input string name);
    @(negedge clock);
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (push) sb.push_back('{res, exc, cyc + 33, name});
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[$];
  int   busy_cnt;

  initial begin
    vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mul_ovf"});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, "mul_min_x1"});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h00000019, 1'b0, "mul_neg_neg"});
    vecs.push_back('{1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1, "mul_max_x2"});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_m7_2"});
    vecs.push_back('{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       1'b0, "div_100_7"});
    vecs.push_back('{1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1, "div_by_zero"});
    vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_min_m1"});
    vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'h00000002, 32'hC0000000, 1'b0, "div_min_2"});
    vecs.push_back('{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, "div_7_m7"});
    vecs.push_back('{1'b1, 1'b1, 32'd6,        32'd3,        32'd18,       1'b0, "both_ctrl"});

    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    checkValue("reset result", bus.data_result, 32'd0);
    checkValue("reset exception", {31'd0, bus.data_exception}, 32'd0);
    checkValue("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    checkValue("reset busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;

    // Busy must cover exactly the 32 iteration cycles
    applyStimulus(1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFD6, 1'b0, "mul_7_m6");
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clock);
    end
    checkValue("busy_cycles", busy_cnt, 32'd32);
    checkValue("busy_low_after_run", {31'd0, bus.busy}, 32'd0);
    waitDrain();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b, 1'b1,
                    vecs[i].res, vecs[i].exc, vecs[i].name);
      waitDrain();
    end

    // Abort: only the second operation may report
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 32'd12, 1'b0, "aborted_mul");
    repeat (10) @(negedge clock);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "restart_div");
    waitDrain();
    repeat (5) @(negedge clock);

    // Reset mid-run: no pulse, outputs cleared
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd1000, 1'b0, 32'd1000000, 1'b0, "reset_mul");
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkValue("midrun_reset result", bus.data_result, 32'd0);
    checkValue("midrun_reset busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clock);
    checkValue("post_reset result", bus.data_result, 32'd0);
    checkValue("post_reset exception", {31'd0, bus.data_exception}, 32'd0);

    // Start issued in the DONE cycle of the previous operation
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, 1'b1, 32'd81, 1'b0, "b2b_first");
    repeat (31) @(negedge clock);
    applyStimulus(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 1'b0, "b2b_second");
    waitDrain();
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
